// File: rtl/user_store.sv
// user_store: per-user record memory (password, admin, lock, wrong-try count) with self-init sweep.
// Ports:
//   clk, rst                               clock, async active-high reset
//   cs                                     access strobe (ignored while busy)
//   pass_rw, admin_rw, lock_rw, count_rw   per-field select, 0 = read, 1 = write
//   addr[11:0]                             BCD username (hundreds, tens, units)
//   pass_in, count_in, admin_in, lock_in   write data
//   pass_out, count_out, admin_out, lock_out  registered read data (write-first)
//   busy                                   high during the init sweep
//   addr_err                               one-cycle pulse after an access with a non-BCD digit
// Build option: USER_STORE_AUTOLOCK_EN forces lock=1 when a count >= MAX_TRY is written.
module user_store #(
  parameter int          DEPTH        = 1000,
  parameter logic [11:0] ADMIN_ADDR   = 12'h000,
  parameter logic [15:0] DEFAULT_PASS = 16'h0000,
  parameter logic [3:0]  MAX_TRY      = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        pass_rw,
  input  logic        admin_rw,
  input  logic        lock_rw,
  input  logic        count_rw,
  input  logic [11:0] addr,
  input  logic [15:0] pass_in,
  input  logic [3:0]  count_in,
  input  logic        admin_in,
  input  logic        lock_in,
  output logic [15:0] pass_out,
  output logic [3:0]  count_out,
  output logic        admin_out,
  output logic        lock_out,
  output logic        busy,
  output logic        addr_err
);
  typedef enum logic [1:0] {RESET, INIT, IDLE} state_t;
  typedef struct packed {
    logic [15:0] pass;
    logic        admin;
    logic        lock;
    logic [3:0]  count;
  } rec_t;

  function automatic logic [9:0] bcd_idx(input logic [11:0] a);
    return 10'(a[11:8]) * 10'd100 + 10'(a[7:4]) * 10'd10 + 10'(a[3:0]);
  endfunction

  localparam logic [9:0] ADMIN_IDX = bcd_idx(ADMIN_ADDR);
  localparam logic [9:0] LAST_IDX  = 10'(DEPTH - 1);

  rec_t       mem [DEPTH];
  state_t     state_q, state_d;
  logic [9:0] idx_q, idx_d;
  rec_t       out_q, out_d;
  logic       err_q, err_d;
  rec_t       rd, upd, wr_data;
  logic       wr_en, bad;
  logic [9:0] acc_idx, wr_idx;

  assign acc_idx = bcd_idx(addr);
  assign bad     = (addr[11:8] > 4'd9) || (addr[7:4] > 4'd9) || (addr[3:0] > 4'd9);
  assign rd      = mem[acc_idx];

  // Record after the access; an unlock also clears the count unless the count is written too.
  always_comb begin
    upd.pass  = pass_rw ? pass_in : rd.pass;
    upd.admin = admin_rw ? admin_in : rd.admin;
    upd.count = count_rw ? count_in : (lock_rw && !lock_in) ? 4'd0 : rd.count;
`ifdef USER_STORE_AUTOLOCK_EN
    upd.lock  = (count_rw && count_in >= MAX_TRY) || (lock_rw ? lock_in : rd.lock);
`else
    upd.lock  = lock_rw ? lock_in : rd.lock;
`endif
  end

`ifndef USER_STORE_AUTOLOCK_EN
  logic unused_max_try;
  assign unused_max_try = ^MAX_TRY;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = acc_idx;
    wr_data = upd;
    case (state_q)
      RESET: begin
        state_d = INIT;
        idx_d   = '0;
      end
      INIT: begin
        wr_en   = 1'b1;
        wr_idx  = idx_q;
        wr_data = '{pass: DEFAULT_PASS, admin: idx_q == ADMIN_IDX, lock: idx_q != ADMIN_IDX, count: 4'd0};
        idx_d   = idx_q == LAST_IDX ? 10'd0 : idx_q + 10'd1;
        state_d = idx_q == LAST_IDX ? IDLE : INIT;
      end
      IDLE: begin
        err_d = cs && bad;
        wr_en = cs && !bad;
        out_d = cs && !bad ? upd : out_q;
      end
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_data;

  assign pass_out  = out_q.pass;
  assign admin_out = out_q.admin;
  assign lock_out  = out_q.lock;
  assign count_out = out_q.count;
  assign busy      = state_q != IDLE;
  assign addr_err  = err_q;
endmodule
